csr_ctrl_slave: RTL and testbench

//  Parametrised memory-mapped CSR block for HLS accelerators: NUM_CFG RW config words,
//  NUM_STAT RO result words, CTRL/STATUS regs with start/done handshake and interrupt.

---
 rtl/csr_ctrl_slave_if.sv | 24 ++
 rtl/csr_ctrl_slave.sv | 124 ++++++++++++
 tb/tb_csr_ctrl_slave.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/csr_ctrl_slave_if.sv
// Host register bus: shared byte address, read/write enables, registered read data, error pulses.
// The master drives address, enables and write data. The slave returns read data and error pulses one cycle later.
interface csr_ctrl_slave_if #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
) ();
  logic [ADDR_BITS-1:0] addr;
  logic                 ren;
  logic                 wen;
  logic [DATA_BITS-1:0] wdata;
  logic [DATA_BITS-1:0] rdata;
  logic                 waddr_error;
  logic                 raddr_error;

  modport master (
    output addr, ren, wen, wdata,
    input  rdata, waddr_error, raddr_error
  );

  modport slave (
    input  addr, ren, wen, wdata,
    output rdata, waddr_error, raddr_error
  );
endinterface

// File: rtl/csr_ctrl_slave.sv
// CSR block between host register bus and an accelerator core: config, results, start/done FSM, irq.
// rdata and error pulses appear 1 cycle after ren/wen. The bus has no backpressure, so every access completes in one cycle.
module csr_ctrl_slave #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32,
  parameter int NUM_CFG   = 3,
  parameter int NUM_STAT  = 1,
  parameter int DEBUG     = 0
) (
  input  logic                          clk,
  input  logic                          arst_n,
  csr_ctrl_slave_if.slave               bus,
  output logic [NUM_CFG*DATA_BITS-1:0]  cfg_dat,
  output logic                          start,
  output logic                          busy,
  input  logic                          done_in,
  input  logic [NUM_STAT*DATA_BITS-1:0] stat_dat,
  output logic                          irq
);
  typedef logic [ADDR_BITS-3:0] word_t;
  typedef logic [DATA_BITS-1:0] data_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;

  localparam word_t W_CTRL   = word_t'(0);
  localparam word_t W_STATUS = word_t'(1);
  localparam word_t W_CFG0   = word_t'(2);
  localparam word_t W_STAT0  = word_t'(2 + NUM_CFG);
  localparam word_t W_END    = word_t'(2 + NUM_CFG + NUM_STAT);

  state_t state_q, state_d;
  data_t  cfg_q  [NUM_CFG];
  data_t  stat_q [NUM_STAT];
  data_t  rdata_q, rd_val;
  logic   irq_en_q, done_q, err_q, waddr_err_q, raddr_err_q;

  word_t              word;
  logic               addr_ok, wr_ok, wr_ctrl, wr_status, wr_start, done_ev, err_ev;
  logic [NUM_CFG-1:0] wr_cfg;
  logic               unused_debug;

  assign unused_debug = (DEBUG != 0);

  assign word      = bus.addr[ADDR_BITS-1:2];
  assign addr_ok   = (bus.addr[1:0] == 2'b00) && (word < W_END);
  assign wr_ok     = bus.wen && addr_ok;
  assign wr_ctrl   = wr_ok && (word == W_CTRL);
  assign wr_status = wr_ok && (word == W_STATUS);
  assign wr_start  = wr_ctrl && bus.wdata[0];
  assign done_ev   = (state_q == S_BUSY) && done_in;
  // A start request outside IDLE or a config write during a run is flagged, never applied.
  assign err_ev    = (wr_start && (state_q != S_IDLE)) || ((|wr_cfg) && busy);

  always_comb begin
    wr_cfg = '0;
    for (int i = 0; i < NUM_CFG; i++)
      wr_cfg[i] = wr_ok && (word == W_CFG0 + word_t'(i));
  end

  always_comb begin
    rd_val = '0;
    if (word == W_CTRL)   rd_val[1]   = irq_en_q;
    if (word == W_STATUS) rd_val[2:0] = {err_q, done_q, busy};
    for (int i = 0; i < NUM_CFG; i++)
      if (word == W_CFG0 + word_t'(i)) rd_val = cfg_q[i];
    for (int j = 0; j < NUM_STAT; j++)
      if (word == W_STAT0 + word_t'(j)) rd_val = stat_q[j];
  end

  always_ff @(posedge clk) begin
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (wr_start) state_d = S_START;
      S_START: state_d = S_BUSY;
      S_BUSY:  if (done_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start = (state_q == S_START);
    busy  = (state_q == S_START) || (state_q == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rdata_q     <= '0;
      waddr_err_q <= 1'b0;
      raddr_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_CFG; i++)  cfg_q[i]  <= '0;
      for (int j = 0; j < NUM_STAT; j++) stat_q[j] <= '0;
    end else begin
      raddr_err_q <= bus.ren && !addr_ok;
      waddr_err_q <= bus.wen && !addr_ok;
      if (bus.ren && addr_ok) rdata_q <= rd_val;
      if (wr_ctrl) irq_en_q <= bus.wdata[1];
      // Hardware set beats a same-cycle software clear.
      done_q <= done_ev || (done_q && !(wr_status && bus.wdata[1]));
      err_q  <= err_ev  || (err_q  && !(wr_status && bus.wdata[2]));
      for (int i = 0; i < NUM_CFG; i++)
        if (wr_cfg[i] && !busy) cfg_q[i] <= bus.wdata;
      if (done_ev)
        for (int j = 0; j < NUM_STAT; j++)
          stat_q[j] <= stat_dat[j*DATA_BITS +: DATA_BITS];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CFG; i++)
      cfg_dat[i*DATA_BITS +: DATA_BITS] = cfg_q[i];
  end

  assign bus.rdata       = rdata_q;
  assign bus.waddr_error = waddr_err_q;
  assign bus.raddr_error = raddr_err_q;
  assign irq             = irq_en_q && done_q;
endmodule

// File: tb/tb_csr_ctrl_slave.sv
// Directed bench for csr_ctrl_slave: bus ops push expected responses, a negedge monitor pops and compares.
module tb_csr_ctrl_slave;
  logic        clk = 1'b0;
  logic        arst_n;
  logic [95:0] cfg_dat;
  logic        start, busy, done_in, irq;
  logic [31:0] stat_dat;

  csr_ctrl_slave_if #(.ADDR_BITS(12), .DATA_BITS(32)) bus ();

  csr_ctrl_slave #(.ADDR_BITS(12), .DATA_BITS(32), .NUM_CFG(3), .NUM_STAT(1), .DEBUG(0)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus), .cfg_dat(cfg_dat), .start(start),
    .busy(busy), .done_in(done_in), .stat_dat(stat_dat), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          re;
    bit          we;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  int          sc0;
  logic        op_fire = 1'b0;
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Flop mirrors what the DUT sampled, so the monitor knows a response is due.
  always @(posedge clk) op_fire <= bus.ren | bus.wen;

  always @(negedge clk) begin
    exp_t e;
    if (start) start_cnt++;
    if (op_fire) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
        e = sb.pop_front();
        if (e.rd) check("rdata", bus.rdata, e.rdata);
        check("raddr_error", 32'(bus.raddr_error), 32'(e.re));
        check("waddr_error", 32'(bus.waddr_error), 32'(e.we));
      end
    end else if (bus.raddr_error || bus.waddr_error) begin
      checks++; errors++;
      $display("FAIL spurious_err actual=%b%b required=00", bus.raddr_error, bus.waddr_error);
    end
  end

  task automatic op(input bit r, input bit w, input logic [11:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input bit exp_re, input bit exp_we);
    exp_t e;
    @(posedge clk); #1;
    bus.ren = r; bus.wen = w; bus.addr = a; bus.wdata = wd; done_in = 1'b0;
    if (r && !exp_re) last_rd = exp_rd;
    e.rd = r; e.rdata = last_rd; e.re = exp_re; e.we = exp_we;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp_rd);
    op(1'b1, 1'b0, a, 32'h0, exp_rd, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    op(1'b0, 1'b1, a, d, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.ren = 1'b0; bus.wen = 1'b0; done_in = 1'b0;
    end
  endtask

  task automatic pulse_done(input logic [31:0] d);
    @(posedge clk); #1;
    bus.ren = 1'b0; bus.wen = 1'b0; done_in = 1'b1; stat_dat = d;
    idle(1);
  endtask

  initial begin
    logic [11:0] offs [6];
    offs = '{12'h0, 12'h4, 12'h8, 12'hC, 12'h10, 12'h14};
    arst_n = 1'b0; bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0;
    done_in = 1'b0; stat_dat = '0;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_busy_start_irq", {29'h0, busy, start, irq}, 32'h0);
    check("rst_cfg0", cfg_dat[31:0], 32'h0);

    // Map reads after reset, then config writes and readback
    for (int i = 0; i < 6; i++) rd(offs[i], 32'h0);
    wr(12'h8, 32'hA5A5A5A5); wr(12'hC, 32'h1); wr(12'h10, 32'hFFFFFFFF);
    idle(1);
    @(negedge clk);
    check("cfg_dat0", cfg_dat[31:0],  32'hA5A5A5A5);
    check("cfg_dat1", cfg_dat[63:32], 32'h1);
    check("cfg_dat2", cfg_dat[95:64], 32'hFFFFFFFF);
    rd(12'h8, 32'hA5A5A5A5); rd(12'hC, 32'h1); rd(12'h10, 32'hFFFFFFFF);
    op(1'b1, 1'b0, 12'hFFC, 32'h0, 32'h0, 1'b1, 1'b0);
    op(1'b1, 1'b0, 12'h002, 32'h0, 32'h0, 1'b1, 1'b0);
    op(1'b1, 1'b1, 12'h8, 32'h5A5A5A5A, 32'hA5A5A5A5, 1'b0, 1'b0);
    rd(12'h8, 32'h5A5A5A5A);
    wr(12'h14, 32'hCAFEF00D); rd(12'h14, 32'h0);
    op(1'b0, 1'b1, 12'h18, 32'h1, 32'h0, 1'b0, 1'b1);
    wr(12'h0, 32'h2); rd(12'h0, 32'h2); rd(12'h4, 32'h0);

    // Normal run with interrupt
    sc0 = start_cnt;
    wr(12'h0, 32'h3);
    idle(1);
    @(negedge clk);
    check("start_pulse_hi", {30'h0, start, busy}, 32'h3);
    @(negedge clk);
    check("start_pulse_lo", {30'h0, start, busy}, 32'h1);
    idle(8);
    pulse_done(32'h1234);
    @(negedge clk);
    check("irq_on_done", {30'h0, irq, busy}, 32'h2);
    check("start_count_run1", 32'(start_cnt - sc0), 32'h1);
    rd(12'h4, 32'h2); rd(12'h14, 32'h1234);
    wr(12'h4, 32'h2);
    idle(1);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'h0);
    rd(12'h4, 32'h0);

    // Writes while busy are rejected and flagged
    sc0 = start_cnt;
    wr(12'h0, 32'h1); wr(12'hC, 32'hDEAD); wr(12'h0, 32'h1);
    rd(12'hC, 32'h1); rd(12'h4, 32'h5);
    pulse_done(32'h5678);
    rd(12'h4, 32'h6);
    @(negedge clk);
    check("start_count_run2", 32'(start_cnt - sc0), 32'h1);
    check("cfg_dat1_locked", cfg_dat[63:32], 32'h1);
    pulse_done(32'h9999);
    rd(12'h14, 32'h5678); rd(12'h4, 32'h6);
    wr(12'h4, 32'h6); rd(12'h4, 32'h0);

    // Done set and W1C in the same cycle; misaligned write
    wr(12'h0, 32'h1);
    idle(3);
    op(1'b0, 1'b1, 12'h4, 32'h2, 32'h0, 1'b0, 1'b0);
    done_in = 1'b1; stat_dat = 32'hABCD;
    idle(1);
    rd(12'h4, 32'h2); rd(12'h14, 32'hABCD);
    wr(12'h4, 32'h2); rd(12'h4, 32'h0);
    op(1'b0, 1'b1, 12'h006, 32'hFFFF, 32'h0, 1'b0, 1'b1);
    idle(1);
    @(negedge clk);
    check("no_start_on_bad_wr", 32'(busy), 32'h0);
    rd(12'h0, 32'h0); rd(12'h4, 32'h0); rd(12'h8, 32'h5A5A5A5A);

    // Reset mid-run
    wr(12'h0, 32'h3);
    idle(3);
    @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'h1);
    @(posedge clk); #1 arst_n = 1'b0; last_rd = 32'h0;
    @(posedge clk); #1 arst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_run", {28'h0, busy, start, irq, 1'b0}, 32'h0);
    check("rst_mid_rdata", bus.rdata, 32'h0);
    pulse_done(32'h7777);
    @(negedge clk);
    check("irq_after_rst_done", 32'(irq), 32'h0);
    rd(12'h4, 32'h0); rd(12'h14, 32'h0); rd(12'h0, 32'h0); rd(12'h8, 32'h0);
    idle(3);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
